// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: 8x8 sprite ROM address generator, pixel qualifier and animation sequencer.
// Define SPRITE_MIRROR_EN to add the h_flip input for horizontally mirrored sprites.
module sprite_pixel_fetch #(
    parameter int         COORD_W    = 10,
    parameter int         NUM_FRAMES = 7,
    parameter int         ANIM_DIV   = 8,
    parameter logic [3:0] TRANSP_IDX = 4'hF,
    parameter logic [8:0] BLANK_ADDR = 9'd448
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic [COORD_W-1:0] sprite_x,
    input  logic [COORD_W-1:0] sprite_y,
    input  logic               sprite_en,
`ifdef SPRITE_MIRROR_EN
    input  logic               h_flip,
`endif
    input  logic [1:0]         anim_cmd,
    output logic [8:0]         rom_addr,
    input  logic [7:0]         rom_data,
    output logic               px_valid,
    output logic               px_hit,
    output logic [3:0]         px_color,
    output logic [2:0]         frame_idx
);
    localparam int W1    = COORD_W + 1;
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div, div_n;
    logic [2:0]         frame_n;
    logic [COORD_W-1:0] x_q, y_q;
    logic               en_q, flip_q;
    logic [W1-1:0]      hx, vy, xl, yl;
    logic [2:0]         dx, dy, col;
    logic               in_box, opaque;
    logic               hit_d1, hit_d2, valid_d1, valid_d2;
    logic               unused_hi;

    assign unused_hi = ^rom_data[7:4];

    // Widened compares so a box at the right/bottom edge never wraps onto column/row 0.
    always_comb begin
        hx     = {1'b0, hcount};
        vy     = {1'b0, vcount};
        xl     = {1'b0, x_q};
        yl     = {1'b0, y_q};
        in_box = pix_valid & en_q & (hx >= xl) & (hx < xl + W1'(8)) & (vy >= yl) & (vy < yl + W1'(8));
        dx     = hcount[2:0] - x_q[2:0];
        dy     = vcount[2:0] - y_q[2:0];
        col    = flip_q ? 3'd7 - dx : dx;
        opaque = hit_d2 & (rom_data[3:0] != TRANSP_IDX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            en_q     <= 1'b0;
            rom_addr <= BLANK_ADDR;
            hit_d1   <= 1'b0;
            hit_d2   <= 1'b0;
            valid_d1 <= 1'b0;
            valid_d2 <= 1'b0;
            px_valid <= 1'b0;
            px_hit   <= 1'b0;
            px_color <= 4'h0;
        end else begin
            if (frame_start) begin
                x_q  <= sprite_x;
                y_q  <= sprite_y;
                en_q <= sprite_en;
            end
            rom_addr <= in_box ? {frame_idx, dy, col} : BLANK_ADDR;
            hit_d1   <= in_box;
            valid_d1 <= pix_valid;
            hit_d2   <= hit_d1;
            valid_d2 <= valid_d1;
            px_valid <= valid_d2;
            px_hit   <= opaque;
            px_color <= opaque ? rom_data[3:0] : 4'h0;
        end
    end

`ifdef SPRITE_MIRROR_EN
    always_ff @(posedge clock) begin
        if (reset) flip_q <= 1'b0;
        else if (frame_start) flip_q <= h_flip;
    end
`else
    assign flip_q = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            div       <= '0;
            frame_idx <= 3'd0;
        end else begin
            state     <= state_n;
            div       <= div_n;
            frame_idx <= frame_n;
        end
    end

    // A command in the same cycle as frame_start suppresses that cycle's advance.
    always_comb begin
        state_n = state;
        div_n   = div;
        frame_n = frame_idx;
        if (anim_cmd == 2'b01) state_n = PLAY;
        else if (anim_cmd == 2'b10) state_n = (state == PLAY) ? PAUSE : state;
        else if (anim_cmd == 2'b11) begin
            state_n = IDLE;
            div_n   = '0;
            frame_n = 3'd0;
        end else if (frame_start && state == PLAY) begin
            div_n = (div == DIV_W'(ANIM_DIV - 1)) ? '0 : div + 1'b1;
            if (div == DIV_W'(ANIM_DIV - 1))
                frame_n = (frame_idx == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_idx + 3'd1;
        end
    end
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// tb_sprite_pixel_fetch: table vectors and hand sequences checked through an address/pixel scoreboard.
module tb_sprite_pixel_fetch;
    logic       clock = 1'b0, reset = 1'b1, frame_start = 1'b0, pix_valid = 1'b0, sprite_en = 1'b0;
    logic [9:0] hcount = '0, vcount = '0, sprite_x = '0, sprite_y = '0;
    logic [1:0] anim_cmd = 2'b00;
    logic [8:0] rom_addr;
    logic [7:0] rom_data = '0;
    logic       px_valid, px_hit;
    logic [3:0] px_color;
    logic [2:0] frame_idx;
`ifdef SPRITE_MIRROR_EN
    logic       h_flip = 1'b0, mflip = 1'b0;
`endif

    logic [7:0] mem [512];
    int         nvec = 0, nerr = 0, cyc = 0;
    int         mx = 0, my = 0;
    logic       men = 1'b0;
    logic [2:0] mframe = 3'd0;

    typedef struct {int due; logic [8:0] addr;} aexp_t;
    typedef struct {int due; logic [5:0] px;} pexp_t;
    typedef struct {int h; int v; logic pv; logic [8:0] addr; logic hit; logic [3:0] color;} vec_t;
    aexp_t aq[$];
    pexp_t pq[$];
    vec_t  tbl[12];

    sprite_pixel_fetch dut (
        .clock(clock), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .hcount(hcount), .vcount(vcount), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_en(sprite_en),
`ifdef SPRITE_MIRROR_EN
        .h_flip(h_flip),
`endif
        .anim_cmd(anim_cmd), .rom_addr(rom_addr), .rom_data(rom_data),
        .px_valid(px_valid), .px_hit(px_hit), .px_color(px_color), .frame_idx(frame_idx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= mem[rom_addr];

    task automatic chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        aexp_t a;
        pexp_t p;
        @(posedge clock);
        #1;
        cyc++;
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            a = aq.pop_front();
            chk("rom_addr", int'(rom_addr), int'(a.addr));
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            chk("px{valid,hit,color}", int'({px_valid, px_hit, px_color}), int'(p.px));
        end
    endtask

    task automatic apply(int h, int v, logic pv, logic [8:0] a, logic hit, logic [3:0] c);
        hcount    = 10'(h);
        vcount    = 10'(v);
        pix_valid = pv;
        aq.push_back('{cyc + 1, a});
        pq.push_back('{cyc + 3, {pv, hit, c}});
        step();
        pix_valid = 1'b0;
    endtask

    task automatic scan(int h, int v);
        logic       inb;
        logic [2:0] col;
        logic [8:0] a;
        logic [3:0] d;
        inb = men && h >= mx && h < mx + 8 && v >= my && v < my + 8;
        col = 3'(h - mx);
`ifdef SPRITE_MIRROR_EN
        if (mflip) col = 3'd7 - col;
`endif
        a = inb ? {mframe, 3'(v - my), col} : 9'd448;
        d = mem[a][3:0];
        apply(h, v, 1'b1, a, inb && d != 4'hF, (inb && d != 4'hF) ? d : 4'h0);
    endtask

    task automatic cmd(logic [1:0] c, logic fs);
        anim_cmd    = c;
        frame_start = fs;
        step();
        anim_cmd    = 2'b00;
        frame_start = 1'b0;
        if (fs) begin
            mx  = int'(sprite_x);
            my  = int'(sprite_y);
            men = sprite_en;
`ifdef SPRITE_MIRROR_EN
            mflip = h_flip;
`endif
        end
    endtask

    task automatic chk_rst(string tag);
        chk({tag, ".rom_addr"}, int'(rom_addr), 448);
        chk({tag, ".px_valid"}, int'(px_valid), 0);
        chk({tag, ".px_hit"}, int'(px_hit), 0);
        chk({tag, ".px_color"}, int'(px_color), 0);
        chk({tag, ".frame_idx"}, int'(frame_idx), 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = {4'h5, 4'(i)};
        mem[20] = 8'h0F;
        mem[21] = 8'h05;
        tbl[0]  = '{103, 52, 1'b1, 9'd19,  1'b1, 4'h3};
        tbl[1]  = '{104, 52, 1'b1, 9'd20,  1'b0, 4'h0};
        tbl[2]  = '{105, 52, 1'b1, 9'd21,  1'b1, 4'h5};
        tbl[3]  = '{108, 52, 1'b1, 9'd448, 1'b0, 4'h0};
        tbl[4]  = '{99,  52, 1'b1, 9'd448, 1'b0, 4'h0};
        tbl[5]  = '{100, 50, 1'b1, 9'd0,   1'b1, 4'h0};
        tbl[6]  = '{106, 57, 1'b1, 9'd62,  1'b1, 4'hE};
        tbl[7]  = '{107, 51, 1'b1, 9'd15,  1'b0, 4'h0};
        tbl[8]  = '{103, 52, 1'b0, 9'd448, 1'b0, 4'h0};
        tbl[9]  = '{103, 58, 1'b1, 9'd448, 1'b0, 4'h0};
        tbl[10] = '{103, 49, 1'b1, 9'd448, 1'b0, 4'h0};
        tbl[11] = '{101, 54, 1'b1, 9'd33,  1'b1, 4'h1};

        repeat (2) step();
        chk_rst("reset");
        reset = 1'b0;

        // Addressing, latency, misses and transparency
        sprite_x  = 10'd100;
        sprite_y  = 10'd50;
        sprite_en = 1'b1;
        cmd(2'b00, 1'b1);
        for (int i = 0; i < 12; i++)
            apply(tbl[i].h, tbl[i].v, tbl[i].pv, tbl[i].addr, tbl[i].hit, tbl[i].color);

        // Animation: play, wrap, pause, command-beats-frame_start, stop
        cmd(2'b01, 1'b0);
        for (int p = 1; p <= 56; p++) begin
            cmd(2'b00, 1'b1);
            chk("anim.play", int'(frame_idx), (p / 8) % 7);
        end
        for (int p = 1; p <= 11; p++) cmd(2'b00, 1'b1);
        chk("anim.div3", int'(frame_idx), 1);
        cmd(2'b10, 1'b0);
        for (int p = 1; p <= 20; p++) begin
            cmd(2'b00, 1'b1);
            chk("anim.pause", int'(frame_idx), 1);
        end
        cmd(2'b01, 1'b1);
        chk("anim.cmd_wins", int'(frame_idx), 1);
        for (int p = 1; p <= 5; p++) begin
            cmd(2'b00, 1'b1);
            chk("anim.resume", int'(frame_idx), p == 5 ? 2 : 1);
        end
        mframe = 3'd2;
        scan(100, 50);
        scan(103, 52);
        cmd(2'b11, 1'b0);
        chk("anim.stop", int'(frame_idx), 0);
        mframe = 3'd0;
        for (int p = 1; p <= 8; p++) cmd(2'b00, 1'b1);
        chk("anim.idle", int'(frame_idx), 0);

        // Shadowing and right-edge box
        sprite_x = 10'd200;
        sprite_y = 10'd100;
        cmd(2'b00, 1'b1);
        for (int h = 196; h < 210; h++) scan(h, 103);
        sprite_x = 10'd300;
        for (int h = 196; h < 210; h++) scan(h, 104);
        cmd(2'b00, 1'b1);
        scan(299, 104);
        scan(300, 104);
        sprite_x = 10'd1020;
        cmd(2'b00, 1'b1);
        for (int h = 1016; h < 1024; h++) scan(h, 101);
        for (int h = 0; h < 6; h++) scan(h, 101);

        // Reset in the middle of in-box pixels
        sprite_x = 10'd200;
        cmd(2'b00, 1'b1);
        cmd(2'b01, 1'b0);
        for (int p = 1; p <= 8; p++) cmd(2'b00, 1'b1);
        chk("anim.pre_reset", int'(frame_idx), 1);
        mframe = 3'd1;
        for (int h = 200; h < 204; h++) scan(h, 100);
        aq.delete();
        pq.delete();
        hcount    = 10'd204;
        vcount    = 10'd100;
        pix_valid = 1'b1;
        reset     = 1'b1;
        step();
        chk_rst("midline_reset");
        reset = 1'b0;
        mx = 0; my = 0; men = 1'b0; mframe = 3'd0;
        for (int i = 0; i < 3; i++) begin
            scan(205 + i, 100);
            chk("post_reset.px_hit", int'(px_hit), 0);
        end
        for (int p = 1; p <= 8; p++) cmd(2'b00, 1'b1);
        chk("post_reset.idle", int'(frame_idx), 0);
        scan(201, 102);

`ifdef SPRITE_MIRROR_EN
        h_flip   = 1'b1;
        sprite_x = 10'd100;
        sprite_y = 10'd50;
        cmd(2'b00, 1'b1);
        scan(100, 50);
        scan(107, 50);
        scan(102, 53);
`endif

        for (int i = 0; i < 8 && (aq.size() > 0 || pq.size() > 0); i++) step();
        nvec++;
        if (aq.size() > 0 || pq.size() > 0) begin
            nerr++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", aq.size(), pq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
